gpr_bypass_rf: RTL and testbench

Parametrised general-purpose register file for the pipelined MIPS datapath, replacing the single-cycle two-read/one-write file. It provides NRD combinational read ports with same-cycle write-through bypass and two write ports: the writeback port and a dedicated link port for jal/jalr. A per-register busy scoreboard lets the decode stage stall on pending long-latency producers such as loads. Register 0 is hardwired to zero.

---
 rtl/gpr_pkg.sv | 22 ++
 rtl/gpr_scoreboard.sv | 54 +++++
 rtl/gpr_bypass_rf.sv | 112 +++++++++++
 tb/tb_gpr_bypass_rf.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_pkg.sv
`default_nettype none
// ============================================================================
// gpr_pkg : shared constants, address type and write-decode helper for the GPR file
// Revision: 1.0
// ============================================================================
package gpr_pkg;

    localparam int GPR_DATA_W  = 32;
    localparam int REG_ZERO    = 0;
    localparam int REG_RA      = 31;
    localparam int GPR_MAX_AW  = 6;
    localparam int GPR_MAX_REG = 1 << GPR_MAX_AW;

    typedef logic [4:0] reg_addr_t;

    // Callers truncate to their own register count.
    function automatic logic [GPR_MAX_REG-1:0] addr_onehot(input logic [GPR_MAX_AW-1:0] addr);
        addr_onehot = {{(GPR_MAX_REG-1){1'b0}}, 1'b1} << addr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpr_scoreboard.sv
`default_nettype none
// ============================================================================
// gpr_scoreboard : per-register busy bits with set-over-clear priority
// Revision: 1.0
// ============================================================================
module gpr_scoreboard
    import gpr_pkg::*;
#(
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG),
    parameter int NRD  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sb_set_en,
    input  logic [AW-1:0]     sb_set_addr,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy
);

    localparam int c_nb = NREG - 1;

    logic [NREG-1:1] busy_q;
    logic [NREG-1:1] busy_d;
    logic [NREG-1:1] w_set_vec;
    logic [NREG-1:1] w_clr_vec;
    logic [NREG-1:0] w_busy_full;

    // Set is applied after clear so a new producer outranks a retiring one.
    always_comb begin
        w_set_vec   = sb_set_en ? c_nb'(addr_onehot(GPR_MAX_AW'(sb_set_addr)) >> 1) : '0;
        w_clr_vec   = wr_en     ? c_nb'(addr_onehot(GPR_MAX_AW'(wr_addr)) >> 1)     : '0;
        busy_d      = (busy_q & ~w_clr_vec) | w_set_vec;
        w_busy_full = {busy_q, 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd_busy
        logic [AW-1:0] w_addr;
        assign w_addr     = rd_addr[i*AW +: AW];
        assign rd_busy[i] = w_busy_full[w_addr] && !(wr_en && (wr_addr == w_addr));
    end

endmodule
`default_nettype wire

// File: rtl/gpr_bypass_rf.sv
`default_nettype none
// ============================================================================
// gpr_bypass_rf : NRD-read register file with write-through bypass, link port and busy scoreboard
// Revision: 1.0
// ============================================================================
module gpr_bypass_rf
    import gpr_pkg::*;
#(
    parameter int DATA_W   = GPR_DATA_W,
    parameter int NREG     = 32,
    parameter int AW       = $clog2(NREG),
    parameter int NRD      = 2,
    parameter int LINK_REG = NREG - 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  link_en,
    input  logic [DATA_W-1:0]     link_data,
    input  logic                  sb_set_en,
    input  logic [AW-1:0]         sb_set_addr
);

    localparam int            c_nb        = NREG - 1;
    localparam logic [AW-1:0] c_link_addr = AW'(LINK_REG);
    localparam logic [AW-1:0] c_zero_addr = AW'(REG_ZERO);

    logic [DATA_W-1:0] regs_q [1:NREG-1];
    logic [DATA_W-1:0] regs_d [1:NREG-1];
    logic [DATA_W-1:0] w_rf   [0:NREG-1];
    logic [NREG-1:1]   w_wr_vec;
    logic [NREG-1:1]   w_link_vec;

    always_comb begin
        w_wr_vec   = wr_en   ? c_nb'(addr_onehot(GPR_MAX_AW'(wr_addr)) >> 1)     : '0;
        w_link_vec = link_en ? c_nb'(addr_onehot(GPR_MAX_AW'(c_link_addr)) >> 1) : '0;
    end

    // The link write belongs to the younger instruction, so it wins a collision.
    always_comb begin
        for (int r = 1; r < NREG; r++) begin
            regs_d[r] = regs_q[r];
            if (w_link_vec[r]) begin
                regs_d[r] = link_data;
            end else if (w_wr_vec[r]) begin
                regs_d[r] = wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 1; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                regs_q[r] <= regs_d[r];
            end
        end
    end

    always_comb begin
        w_rf[0] = '0;
        for (int r = 1; r < NREG; r++) begin
            w_rf[r] = regs_q[r];
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd_port
        logic [AW-1:0]     w_addr;
        logic [DATA_W-1:0] w_data;

        assign w_addr = rd_addr[i*AW +: AW];

        always_comb begin
            if (!rst_n || (w_addr == c_zero_addr)) begin
                w_data = '0;
            end else if (link_en && (w_addr == c_link_addr)) begin
                w_data = link_data;
            end else if (wr_en && (w_addr == wr_addr)) begin
                w_data = wr_data;
            end else begin
                w_data = w_rf[w_addr];
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = w_data;
    end

    gpr_scoreboard #(
        .NREG (NREG),
        .AW   (AW),
        .NRD  (NRD)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .rd_addr     (rd_addr),
        .rd_busy     (rd_busy)
    );

endmodule
`default_nettype wire

// File: tb/tb_gpr_bypass_rf.sv
`default_nettype none
// ============================================================================
// tb_gpr_bypass_rf : drives a 32x32/2-port and a 16x64/4-port instance with shared stimulus
// Revision: 1.0
// ============================================================================
module tb_gpr_bypass_rf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        wr_en;
    logic        link_en;
    logic        sb_set_en;
    logic [4:0]  wa;
    logic [4:0]  sa;
    logic [63:0] wd;
    logic [63:0] ld;
    logic [4:0]  ra [4];

    logic [9:0]   rd_addr0;
    logic [15:0]  rd_addr1;
    logic [63:0]  rd_data0;
    logic [255:0] rd_data1;
    logic [1:0]   rd_busy0;
    logic [3:0]   rd_busy1;

    assign rd_addr0 = {ra[1], ra[0]};
    assign rd_addr1 = {ra[3][3:0], ra[2][3:0], ra[1][3:0], ra[0][3:0]};

    gpr_bypass_rf u_dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_addr     (rd_addr0),
        .rd_data     (rd_data0),
        .rd_busy     (rd_busy0),
        .wr_en       (wr_en),
        .wr_addr     (wa),
        .wr_data     (wd[31:0]),
        .link_en     (link_en),
        .link_data   (ld[31:0]),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sa)
    );

    gpr_bypass_rf #(
        .DATA_W (64),
        .NREG   (16),
        .NRD    (4)
    ) u_dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_addr     (rd_addr1),
        .rd_data     (rd_data1),
        .rd_busy     (rd_busy1),
        .wr_en       (wr_en),
        .wr_addr     (wa[3:0]),
        .wr_data     (wd),
        .link_en     (link_en),
        .link_data   (ld),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sa[3:0])
    );

    // Architectural model: instance 0 is 32 regs x 32 bits, instance 1 is 16 regs x 64 bits.
    logic [63:0] m_reg  [2][32];
    logic        m_busy [2][32];

    function automatic int amask(input int k, input logic [4:0] a);
        return (k != 0) ? int'(a[3:0]) : int'(a);
    endfunction

    function automatic logic [63:0] dmask(input int k, input logic [63:0] v);
        return (k != 0) ? v : {32'b0, v[31:0]};
    endfunction

    function automatic int lreg(input int k);
        return (k != 0) ? 15 : 31;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                for (int r = 0; r < 32; r++) begin
                    m_reg[k][r]  = '0;
                    m_busy[k][r] = 1'b0;
                end
            end else begin
                if (wr_en && amask(k, wa) != 0) m_reg[k][amask(k, wa)] = dmask(k, wd);
                if (link_en)                    m_reg[k][lreg(k)]      = dmask(k, ld);
                if (wr_en)                      m_busy[k][amask(k, wa)] = 1'b0;
                if (sb_set_en && amask(k, sa) != 0) m_busy[k][amask(k, sa)] = 1'b1;
            end
        end
    end

    function automatic logic [63:0] exp_data(input int k, input logic [4:0] a_raw);
        int a = amask(k, a_raw);
        if (!rst_n || a == 0)                 return '0;
        if (link_en && a == lreg(k))          return dmask(k, ld);
        if (wr_en && a == amask(k, wa))       return dmask(k, wd);
        return m_reg[k][a];
    endfunction

    function automatic logic exp_busy(input int k, input logic [4:0] a_raw);
        int a = amask(k, a_raw);
        if (!rst_n || a == 0) return 1'b0;
        return m_busy[k][a] && !(wr_en && a == amask(k, wa));
    endfunction

    // Hand-computed expectations for the current cycle, per read port.
    logic        lit_en [4];
    logic [31:0] lit_d0 [4];
    logic [63:0] lit_d1 [4];
    logic        lit_b  [4];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input int k, input int p,
                         input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d port%0d t=%0t: got %h expected %h", nm, k, p, $time, act, exp);
        end
    endtask

    logic [63:0] act_d;
    logic        act_b;
    logic [63:0] lit_d;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < ((k != 0) ? 4 : 2); p++) begin
                act_d = (k != 0) ? rd_data1[p*64 +: 64] : {32'b0, rd_data0[p*32 +: 32]};
                act_b = (k != 0) ? rd_busy1[p] : rd_busy0[p];
                check("rd_data", k, p, act_d, exp_data(k, ra[p]));
                check("rd_busy", k, p, {63'b0, act_b}, {63'b0, exp_busy(k, ra[p])});
                if (lit_en[p]) begin
                    lit_d = (k != 0) ? lit_d1[p] : {32'b0, lit_d0[p]};
                    check("lit_data",   k, p, act_d, lit_d);
                    check("model_data", k, p, exp_data(k, ra[p]), lit_d);
                    check("lit_busy",   k, p, {63'b0, act_b}, {63'b0, lit_b[p]});
                    check("model_busy", k, p, {63'b0, exp_busy(k, ra[p])}, {63'b0, lit_b[p]});
                end
            end
        end
    end

    task automatic set_lit(input int p, input logic [31:0] d0, input logic [63:0] d1, input logic b);
        lit_en[p] = 1'b1;
        lit_d0[p] = d0;
        lit_d1[p] = d1;
        lit_b[p]  = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int p = 0; p < 4; p++) lit_en[p] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; link_en = 1'b0; sb_set_en = 1'b0;
        wa = '0; sa = '0; wd = '0; ld = '0;
        for (int p = 0; p < 4; p++) begin
            ra[p] = 5'd0;
            lit_en[p] = 1'b0;
        end
        @(posedge clk);
        #1;

        // Reset held, then released; sweep every address on every port
        wr_en = 1'b1; wa = 5'd6; wd = 64'hFFFF_FFFF_FFFF_FFFF; ra[0] = 5'd6;
        for (int p = 0; p < 4; p++) set_lit(p, 32'h0, 64'h0, 1'b0);
        tick;
        wr_en = 1'b0;
        rst_n = 1'b1;
        for (int a = 0; a < 32; a++) begin
            for (int p = 0; p < 4; p++) begin
                ra[p] = 5'(a + 7 * p);
                set_lit(p, 32'h0, 64'h0, 1'b0);
            end
            tick;
        end

        // r0 write is discarded
        wr_en = 1'b1; wa = 5'd0; wd = 64'h0123_4567_DEAD_BEEF; ra[0] = 5'd0;
        set_lit(0, 32'h0, 64'h0, 1'b0);
        tick;
        wr_en = 1'b0;
        set_lit(0, 32'h0, 64'h0, 1'b0);
        tick;

        // Same-cycle bypass then storage on r5
        wr_en = 1'b1; wa = 5'd5; wd = 64'hFFFF_0000_0000_1234; ra[1] = 5'd5;
        set_lit(1, 32'h1234, 64'hFFFF_0000_0000_1234, 1'b0);
        tick;
        wr_en = 1'b0;
        repeat (3) begin
            set_lit(1, 32'h1234, 64'hFFFF_0000_0000_1234, 1'b0);
            tick;
        end

        // Writeback and link collide on the link register
        wr_en = 1'b1; wa = 5'd31; wd = 64'h1111_1111_AAAA_0000;
        link_en = 1'b1; ld = 64'h2222_2222_0040_0008; ra[0] = 5'd31;
        set_lit(0, 32'h0040_0008, 64'h2222_2222_0040_0008, 1'b0);
        tick;
        wr_en = 1'b0; link_en = 1'b0;
        set_lit(0, 32'h0040_0008, 64'h2222_2222_0040_0008, 1'b0);
        tick;

        // Reserve r8, hold busy, then clear with a bypassed writeback
        sb_set_en = 1'b1; sa = 5'd8; ra[0] = 5'd8;
        set_lit(0, 32'h0, 64'h0, 1'b0);
        tick;
        sb_set_en = 1'b0;
        repeat (3) begin
            set_lit(0, 32'h0, 64'h0, 1'b1);
            tick;
        end
        wr_en = 1'b1; wa = 5'd8; wd = 64'h0000_0000_0000_0055;
        set_lit(0, 32'h55, 64'h55, 1'b0);
        tick;
        wr_en = 1'b0;
        repeat (2) begin
            set_lit(0, 32'h55, 64'h55, 1'b0);
            tick;
        end

        // Set and clear of r9 together: the new reservation survives
        sb_set_en = 1'b1; sa = 5'd9; wr_en = 1'b1; wa = 5'd9;
        wd = 64'hBBBB_0000_0000_0099; ra[1] = 5'd9;
        set_lit(1, 32'h99, 64'hBBBB_0000_0000_0099, 1'b0);
        tick;
        sb_set_en = 1'b0; wr_en = 1'b0;
        repeat (2) begin
            set_lit(1, 32'h99, 64'hBBBB_0000_0000_0099, 1'b1);
            tick;
        end

        // Link-only write, observed on the wide instance's upper ports
        link_en = 1'b1; ld = 64'h3333_4444_0040_0100; ra[2] = 5'd15; ra[3] = 5'd31;
        set_lit(2, 32'h0, 64'h3333_4444_0040_0100, 1'b0);
        tick;
        link_en = 1'b0; ra[0] = 5'd31;
        set_lit(0, 32'h0040_0100, 64'h3333_4444_0040_0100, 1'b0);
        set_lit(3, 32'h0, 64'h3333_4444_0040_0100, 1'b0);
        tick;

        // Mid-cycle reset wipes r3 and the r4 reservation before any edge
        wr_en = 1'b1; wa = 5'd3; wd = 64'h7777_0000_0000_0007;
        sb_set_en = 1'b1; sa = 5'd4;
        tick;
        wr_en = 1'b0; sb_set_en = 1'b0; ra[0] = 5'd3; ra[1] = 5'd4;
        set_lit(0, 32'h7, 64'h7777_0000_0000_0007, 1'b0);
        set_lit(1, 32'h0, 64'h0, 1'b1);
        tick;
        #2;
        rst_n = 1'b0;
        set_lit(0, 32'h0, 64'h0, 1'b0);
        set_lit(1, 32'h0, 64'h0, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        tick;
        set_lit(0, 32'h0, 64'h0, 1'b0);
        set_lit(1, 32'h0, 64'h0, 1'b0);
        ra[2] = 5'd5; ra[3] = 5'd8;
        set_lit(2, 32'h0, 64'h0, 1'b0);
        set_lit(3, 32'h0, 64'h0, 1'b0);
        tick;

        tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
